// File: rtl/date_pkg.sv
// date_pkg: shared constants and helpers for the calendar-date counter.
// Select codes, month constants, field widths and the leap-year test.
package date_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [2:0] SEL_DAY   = 3'b011;
  localparam logic [2:0] SEL_MONTH = 3'b100;
  localparam logic [2:0] SEL_YEAR  = 3'b101;

  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  function automatic logic is_leap(
    input int unsigned y
  );
    return ((y % 4 == 0) && (y % 100 != 0))
        || (y % 400 == 0);
  endfunction

endpackage

// File: rtl/month_len.sv
// month_len: combinational days-in-month lookup.
// Ports: month (1..12), leap (Feb has 29) -> dim (28..31).
module month_len
  import date_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic               leap,
  output logic [DAY_W-1:0]   dim
);

  always_comb begin
    dim = 5'd31;
    case (month)
      4'd4, 4'd6,
      4'd9, 4'd11: dim = 5'd30;
      FEB:         dim = leap ? 5'd29 : 5'd28;
      default:     dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// date_counter: day/month/year counter with editing, clamping and year wrap.
// Ports: clk_1Hz, rst_n, en_1, carry_in, select_item, up, down -> day, month, year_bin, leap_year, year_wrap.
module date_counter
  import date_pkg::*;
#(
  parameter logic [2:0] SELECT_DAY   = SEL_DAY,
  parameter logic [2:0] SELECT_MONTH = SEL_MONTH,
  parameter logic [2:0] SELECT_YEAR  = SEL_YEAR,
  parameter int         YEAR_W       = 12,
  parameter logic [YEAR_W-1:0] YEAR_MIN = YEAR_W'(2001),
  parameter logic [YEAR_W-1:0] YEAR_MAX = YEAR_W'(3000)
) (
  input  logic              clk_1Hz,
  input  logic              rst_n,
  input  logic              en_1,
  input  logic              carry_in,
  input  logic [2:0]        select_item,
  input  logic              up,
  input  logic              down,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year_bin,
  output logic              leap_year,
  output logic              year_wrap
);

  logic [DAY_W-1:0]   r_day;
  logic [MONTH_W-1:0] r_month;
  logic [YEAR_W-1:0]  r_year;
  logic               r_wrap;

  logic               w_sel_d, w_sel_m, w_sel_y;
  logic               w_edit, w_count, w_step;
  logic               w_month_ok, w_day_ok;
  logic [DAY_W-1:0]   w_dim, w_dim_nx;
  logic [DAY_W-1:0]   w_day_ed, w_day_clamp;
  logic [MONTH_W-1:0] w_month_nx;
  logic [YEAR_W-1:0]  w_year_nx;
  logic               w_leap_nx;

  assign day       = r_day;
  assign month     = r_month;
  assign year_bin  = r_year;
  assign year_wrap = r_wrap;
  assign leap_year = is_leap(32'(r_year));

  assign w_sel_d = (select_item == SELECT_DAY);
  assign w_sel_m = (select_item == SELECT_MONTH);
  assign w_sel_y = (select_item == SELECT_YEAR);
  assign w_edit  = w_sel_d | w_sel_m | w_sel_y;
  assign w_step  = up | down;
  assign w_count = !w_edit && en_1 && carry_in;

  assign w_month_ok = (r_month != '0) && (r_month <= DEC);
  assign w_day_ok   = (r_day != '0) && (r_day <= w_dim);

  month_len u_len_cur (
    .month (r_month),
    .leap  (leap_year),
    .dim   (w_dim)
  );

  // Candidate month/year after an edit; the clamp is judged against these.
  always_comb begin
    w_month_nx = r_month;
    w_year_nx  = r_year;
    if (w_sel_m && w_step) begin
      if (!w_month_ok)
        w_month_nx = 4'd1;
      else if (up)
        w_month_nx = (r_month == DEC) ? 4'd1 : r_month + 4'd1;
      else
        w_month_nx = (r_month == 4'd1) ? DEC : r_month - 4'd1;
    end
    if (w_sel_y && w_step) begin
      if (up)
        w_year_nx = (r_year >= YEAR_MAX) ? YEAR_MIN
                                         : r_year + YEAR_W'(1);
      else
        w_year_nx = (r_year <= YEAR_MIN) ? YEAR_MAX
                                         : r_year - YEAR_W'(1);
    end
  end

  assign w_leap_nx = is_leap(32'(w_year_nx));

  month_len u_len_nx (
    .month (w_month_nx),
    .leap  (w_leap_nx),
    .dim   (w_dim_nx)
  );

  always_comb begin
    w_day_clamp = r_day;
    if (r_day == '0)
      w_day_clamp = 5'd1;
    else if (r_day > w_dim_nx)
      w_day_clamp = w_dim_nx;
  end

  always_comb begin
    w_day_ed = 5'd1;
    if (!w_day_ok)
      w_day_ed = 5'd1;
    else if (up)
      w_day_ed = (r_day == w_dim) ? 5'd1 : r_day + 5'd1;
    else
      w_day_ed = (r_day == 5'd1) ? w_dim : r_day - 5'd1;
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_day   <= 5'd1;
      r_month <= 4'd1;
      r_year  <= YEAR_MIN;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_edit) begin
        if (w_step) begin
          if (w_sel_d) begin
            r_day <= w_day_ed;
          end else begin
            r_month <= w_month_nx;
            r_year  <= w_year_nx;
            r_day   <= w_day_clamp;
          end
        end
      end else if (w_count) begin
        if (!w_month_ok) begin
          r_month <= 4'd1;
          r_day   <= 5'd1;
        end else if (!w_day_ok) begin
          r_day <= 5'd1;
        end else if (r_day < w_dim) begin
          r_day <= r_day + 5'd1;
        end else begin
          r_day <= 5'd1;
          if (r_month == DEC) begin
            r_month <= 4'd1;
            if (r_year >= YEAR_MAX) begin
              r_year <= YEAR_MIN;
              r_wrap <= 1'b1;
            end else begin
              r_year <= r_year + YEAR_W'(1);
            end
          end else begin
            r_month <= r_month + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter: table-driven scoreboard bench for date_counter.
// Drives at negedge, pushes expected date, pops and compares after posedge.
module tb_date_counter;
  import date_pkg::*;

  logic        clk_1Hz = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_1 = 1'b0;
  logic        carry_in = 1'b0;
  logic [2:0]  select_item = 3'b000;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year_bin;
  logic        leap_year;
  logic        year_wrap;

  date_counter dut (
    .clk_1Hz     (clk_1Hz),
    .rst_n       (rst_n),
    .en_1        (en_1),
    .carry_in    (carry_in),
    .select_item (select_item),
    .up          (up),
    .down        (down),
    .day         (day),
    .month       (month),
    .year_bin    (year_bin),
    .leap_year   (leap_year),
    .year_wrap   (year_wrap)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    logic [4:0]  d;
    logic [3:0]  m;
    logic [11:0] y;
    logic        w;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic       u;
    logic       dn;
    logic       en;
    logic       c;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic leap_m(input int unsigned y);
    if (y % 400 == 0) return 1'b1;
    if (y % 100 == 0) return 1'b0;
    return (y % 4 == 0);
  endfunction

  function automatic exp_t mk(input int d, input int m,
                              input int y, input bit w);
    exp_t e;
    e.d = 5'(d);
    e.m = 4'(m);
    e.y = 12'(y);
    e.w = w;
    return e;
  endfunction

  task automatic chk(input string name, input exp_t e);
    logic lp;
    lp = leap_m(int'(e.y));
    checks++;
    if (day !== e.d || month !== e.m || year_bin !== e.y ||
        year_wrap !== e.w || leap_year !== lp) begin
      errors++;
      $display("FAIL %s: got %0d/%0d/%0d wrap=%0b leap=%0b want %0d/%0d/%0d wrap=%0b leap=%0b",
               name, day, month, year_bin, year_wrap, leap_year,
               e.d, e.m, e.y, e.w, lp);
    end
  endtask

  task automatic step(input string name, input logic [2:0] sel,
                      input logic u, input logic dn,
                      input logic en, input logic c, input exp_t e);
    @(negedge clk_1Hz);
    select_item = sel;
    up = u;
    down = dn;
    en_1 = en;
    carry_in = c;
    exp_q.push_back(e);
    @(posedge clk_1Hz);
    #1;
    chk(name, exp_q.pop_front());
  endtask

  task automatic add(input logic [2:0] sel, input logic u,
                     input logic dn, input logic en, input logic c,
                     input int d, input int m, input int y,
                     input bit w);
    vec_t v;
    v.sel = sel;
    v.u = u;
    v.dn = dn;
    v.en = en;
    v.c = c;
    v.e = mk(d, m, y, w);
    tbl.push_back(v);
  endtask

  task automatic year_run(input int n, input int d,
                          input int m, input int y0);
    for (int i = 0; i < n; i++)
      step("year_up", SEL_YEAR, 1'b1, 1'b0, 1'b0, 1'b0,
           mk(d, m, y0 + i + 1, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    add(3'b000, 0, 0, 0, 1,  1,  2, 2001, 0);
    add(3'b000, 0, 0, 1, 0,  1,  2, 2001, 0);
    add(SEL_DAY, 0, 1, 0, 0, 28,  2, 2001, 0);
    add(3'b000, 0, 0, 1, 1,  1,  3, 2001, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 1, 2, 2001, 0);
    add(SEL_DAY, 0, 1, 0, 0, 28,  2, 2001, 0);
    add(SEL_YEAR, 1, 0, 0, 0, 28, 2, 2002, 0);
    add(SEL_YEAR, 1, 0, 0, 0, 28, 2, 2003, 0);
    add(SEL_YEAR, 1, 0, 0, 0, 28, 2, 2004, 0);
    add(3'b000, 0, 0, 1, 1, 29,  2, 2004, 0);
    add(3'b000, 0, 0, 1, 1,  1,  3, 2004, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 1, 2, 2004, 0);
    add(SEL_DAY, 0, 1, 0, 0, 29,  2, 2004, 0);
    add(SEL_YEAR, 1, 0, 0, 0, 28, 2, 2005, 0);
    add(SEL_DAY, 1, 0, 0, 0,  1,  2, 2005, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 1, 1, 2005, 0);
    add(SEL_DAY, 0, 1, 0, 0, 31,  1, 2005, 0);
    add(SEL_YEAR, 0, 1, 0, 0, 31, 1, 2004, 0);
    add(SEL_YEAR, 0, 1, 0, 0, 31, 1, 2003, 0);
    add(SEL_YEAR, 0, 1, 0, 0, 31, 1, 2002, 0);
    add(SEL_YEAR, 0, 1, 0, 0, 31, 1, 2001, 0);
    add(SEL_MONTH, 1, 0, 0, 0, 28, 2, 2001, 0);
    add(SEL_YEAR, 0, 1, 0, 0, 28, 2, 3000, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 28, 1, 3000, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 28, 12, 3000, 0);
    add(SEL_DAY, 1, 0, 0, 0, 29, 12, 3000, 0);
    add(SEL_DAY, 1, 0, 0, 0, 30, 12, 3000, 0);
    add(SEL_DAY, 1, 0, 0, 0, 31, 12, 3000, 0);
    add(3'b000, 0, 0, 1, 1,  1,  1, 2001, 1);
    add(3'b000, 0, 0, 1, 0,  1,  1, 2001, 0);
    add(SEL_YEAR, 0, 1, 0, 0,  1, 1, 3000, 0);
    add(SEL_YEAR, 1, 0, 0, 0,  1, 1, 2001, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 1, 12, 2001, 0);
    add(SEL_MONTH, 1, 0, 0, 0, 1, 1, 2001, 0);
    add(SEL_MONTH, 1, 0, 0, 0, 1, 2, 2001, 0);
    add(SEL_MONTH, 1, 0, 0, 0, 1, 3, 2001, 0);
    add(SEL_MONTH, 1, 0, 0, 0, 1, 4, 2001, 0);
    add(SEL_DAY, 0, 1, 0, 0, 30,  4, 2001, 0);
    add(SEL_DAY, 1, 1, 0, 0,  1,  4, 2001, 0);
    add(SEL_DAY, 0, 0, 1, 1,  1,  4, 2001, 0);
    add(SEL_YEAR, 0, 0, 1, 1,  1, 4, 2001, 0);
    add(3'b110, 0, 0, 1, 1,  2,  4, 2001, 0);
    add(SEL_DAY, 0, 1, 0, 0,  1,  4, 2001, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 1, 3, 2001, 0);
    add(SEL_MONTH, 0, 1, 0, 0, 1, 2, 2001, 0);
    add(SEL_DAY, 0, 1, 0, 0, 28,  2, 2001, 0);

    #12;
    chk("reset", mk(1, 1, 2001, 0));
    @(negedge clk_1Hz);
    rst_n = 1'b1;

    for (int i = 1; i <= 31; i++)
      step("jan_count", 3'b000, 1'b0, 1'b0, 1'b1, 1'b1,
           (i < 31) ? mk(i + 1, 1, 2001, 0) : mk(1, 2, 2001, 0));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].sel, tbl[i].u,
           tbl[i].dn, tbl[i].en, tbl[i].c, tbl[i].e);

    year_run(99, 28, 2, 2001);
    step("y2100_cnt", 3'b000, 0, 0, 1, 1, mk(1, 3, 2100, 0));
    step("y2100_m", SEL_MONTH, 0, 1, 0, 0, mk(1, 2, 2100, 0));
    step("y2100_d", SEL_DAY, 0, 1, 0, 0, mk(28, 2, 2100, 0));
    year_run(300, 28, 2, 2100);
    step("y2400_cnt", 3'b000, 0, 0, 1, 1, mk(29, 2, 2400, 0));
    year_run(600, 28, 2, 2400);
    step("y3000_m1", SEL_MONTH, 0, 1, 0, 0, mk(28, 1, 3000, 0));
    step("y3000_m2", SEL_MONTH, 0, 1, 0, 0, mk(28, 12, 3000, 0));
    step("y3000_d1", SEL_DAY, 1, 0, 0, 0, mk(29, 12, 3000, 0));
    step("y3000_d2", SEL_DAY, 1, 0, 0, 0, mk(30, 12, 3000, 0));
    step("y3000_d3", SEL_DAY, 1, 0, 0, 0, mk(31, 12, 3000, 0));

    @(negedge clk_1Hz);
    select_item = 3'b000;
    up = 1'b0;
    down = 1'b0;
    en_1 = 1'b1;
    carry_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", mk(1, 1, 2001, 0));
    @(posedge clk_1Hz);
    #1;
    chk("rst_hold", mk(1, 1, 2001, 0));
    @(negedge clk_1Hz);
    carry_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk_1Hz);
    #1;
    chk("post_rst", mk(1, 1, 2001, 0));
    step("post_cnt", 3'b000, 0, 0, 1, 1, mk(2, 1, 2001, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
